// File: rtl/lcd_pkg.sv
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared types for the LCD panel power sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int PWM_BITS = 8;

  typedef logic [PWM_BITS-1:0] level_t;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_POWER_UP   = 3'd1,
    ST_RAMP_UP    = 3'd2,
    ST_ON         = 3'd3,
    ST_RAMP_DOWN  = 3'd4,
    ST_POWER_DOWN = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_backlight_pwm.sv
// ============================================================================
// Module : lcd_backlight_pwm
// Brief  : Tick-enabled 256-step backlight PWM generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_backlight_pwm
  import lcd_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   tick,
  input  level_t level,
  output logic   pwm
);

  level_t cnt_q, cnt_d;
  logic   pwm_q, pwm_d;

  // Compare uses the pre-increment count so a full period covers 0..255.
  always_comb begin
    cnt_d = cnt_q;
    pwm_d = pwm_q;
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      pwm_d = (cnt_q < level);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

`default_nettype wire

// File: rtl/lcd_power_sequencer.sv
// ============================================================================
// Module : lcd_power_sequencer
// Brief  : Panel DISP / backlight power sequencing with fade in and fade out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_power_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned ON_DELAY_FRAMES  = 10,
  parameter int unsigned OFF_DELAY_FRAMES = 10,
  parameter int unsigned RAMP_INC         = 8,
  parameter int unsigned FRAME_CNT_BITS   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       next_frame,
  input  logic       enable,
  input  logic [7:0] brightness,
  output logic       display_on,
  output logic       backlight_pwm,
  output logic       pixels_enable,
  output logic [7:0] level,
  output logic [2:0] state
);

  localparam logic [8:0]              INC9       = RAMP_INC[8:0];
  localparam logic [FRAME_CNT_BITS:0] ON_TARGET  = ON_DELAY_FRAMES[FRAME_CNT_BITS:0];
  localparam logic [FRAME_CNT_BITS:0] OFF_TARGET = OFF_DELAY_FRAMES[FRAME_CNT_BITS:0];

  state_t                    state_q, state_d;
  level_t                    level_q, level_d;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic                      display_on_q, pixels_enable_q;

  logic [FRAME_CNT_BITS:0] frame_inc;
  logic [8:0]              lvl_up, lvl_dn;
  level_t                  ramp_up_val, ramp_dn_val, track_val;

  assign frame_inc = {1'b0, frame_cnt_q} + 1'b1;

  // 9-bit sums so neither direction can wrap; bit 8 of lvl_dn flags underflow.
  assign lvl_up      = {1'b0, level_q} + INC9;
  assign lvl_dn      = {1'b0, level_q} - INC9;
  assign ramp_up_val = (lvl_up > {1'b0, brightness}) ? brightness : lvl_up[7:0];
  assign ramp_dn_val = lvl_dn[8] ? '0 : lvl_dn[7:0];
  assign track_val   = (level_q <= brightness) ? ramp_up_val :
                       (lvl_dn[8] || (lvl_dn[7:0] < brightness)) ? brightness : lvl_dn[7:0];

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_OFF: begin
        level_d = '0;
        if (enable) state_d = ST_POWER_UP;
      end
      ST_POWER_UP: begin
        level_d = '0;
        if (!enable)                                   state_d = ST_POWER_DOWN;
        else if (next_frame && (frame_inc == ON_TARGET)) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!enable) begin
          state_d = ST_RAMP_DOWN;
        end else if (next_frame) begin
          level_d = ramp_up_val;
          if (ramp_up_val == brightness) state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!enable)         state_d = ST_RAMP_DOWN;
        else if (next_frame) level_d = track_val;
      end
      ST_RAMP_DOWN: begin
        if (enable) begin
          state_d = ST_RAMP_UP;
        end else if (next_frame) begin
          level_d = ramp_dn_val;
          if (ramp_dn_val == '0) state_d = ST_POWER_DOWN;
        end
      end
      ST_POWER_DOWN: begin
        level_d = '0;
        if (next_frame && (frame_inc == OFF_TARGET)) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
        level_d = '0;
      end
    endcase

    // The settle counter restarts on every state entry.
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) frame_cnt_d = '0;
    else if (next_frame)    frame_cnt_d = frame_inc[FRAME_CNT_BITS-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_OFF;
      level_q         <= '0;
      frame_cnt_q     <= '0;
      display_on_q    <= 1'b0;
      pixels_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      frame_cnt_q     <= frame_cnt_d;
      display_on_q    <= (state_d != ST_OFF);
      pixels_enable_q <= (state_d == ST_RAMP_UP) || (state_d == ST_ON) ||
                         (state_d == ST_RAMP_DOWN);
    end
  end

  lcd_backlight_pwm u_pwm (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .level (level_q),
    .pwm   (backlight_pwm)
  );

  assign display_on    = display_on_q;
  assign pixels_enable = pixels_enable_q;
  assign level         = level_q;
  assign state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_power_sequencer.sv
// ============================================================================
// Module : tb_lcd_power_sequencer
// Brief  : Self-checking bench for lcd_power_sequencer with reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_power_sequencer;

  localparam int ON_DELAY  = 10;
  localparam int OFF_DELAY = 10;
  localparam int INC       = 8;

  logic       clock, reset, tick, next_frame, enable;
  logic [7:0] brightness;
  logic       display_on, backlight_pwm, pixels_enable;
  logic [7:0] level;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;
  bit tick_auto = 0;

  lcd_power_sequencer #(
    .ON_DELAY_FRAMES  (ON_DELAY),
    .OFF_DELAY_FRAMES (OFF_DELAY),
    .RAMP_INC         (INC),
    .FRAME_CNT_BITS   (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .next_frame    (next_frame),
    .enable        (enable),
    .brightness    (brightness),
    .display_on    (display_on),
    .backlight_pwm (backlight_pwm),
    .pixels_enable (pixels_enable),
    .level         (level),
    .state         (state)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase name plus integer level, frames seen and PWM position.
  int m_state = 0, m_level = 0, m_frames = 0, m_cnt = 0;
  int m_pwm = 0, m_disp = 0, m_pix = 0;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  always @(posedge clock) begin
    int nxt, nl, b;
    if (reset) begin
      m_state = 0; m_level = 0; m_frames = 0; m_cnt = 0;
      m_pwm = 0; m_disp = 0; m_pix = 0;
    end else begin
      b = int'(brightness);
      if (tick) begin
        m_pwm = (m_cnt < m_level) ? 1 : 0;
        m_cnt = (m_cnt + 1) % 256;
      end
      nxt = m_state;
      nl  = m_level;
      case (m_state)
        0: if (enable) nxt = 1;
        1: if (!enable) nxt = 5;
           else if (next_frame && m_frames + 1 == ON_DELAY) nxt = 2;
        2: if (!enable) nxt = 4;
           else if (next_frame) begin
             nl = imin(m_level + INC, b);
             if (nl == b) nxt = 3;
           end
        3: if (!enable) nxt = 4;
           else if (next_frame)
             nl = (b >= m_level) ? imin(m_level + INC, b) : imax(m_level - INC, b);
        4: if (enable) nxt = 2;
           else if (next_frame) begin
             nl = imax(m_level - INC, 0);
             if (nl == 0) nxt = 5;
           end
        default: if (next_frame && m_frames + 1 == OFF_DELAY) nxt = 0;
      endcase
      if (nxt != m_state) m_frames = 0;
      else if (next_frame) m_frames = m_frames + 1;
      m_state = nxt;
      m_level = nl;
      m_disp  = (nxt != 0) ? 1 : 0;
      m_pix   = (nxt >= 2 && nxt <= 4) ? 1 : 0;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("model_state", 32'(state), m_state);
      check("model_level", 32'(level), m_level);
      check("model_display_on", 32'(display_on), m_disp);
      check("model_pixels_enable", 32'(pixels_enable), m_pix);
      check("model_pwm", 32'(backlight_pwm), m_pwm);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
    next_frame = 1'b0;
    if (tick_auto) tick = ~tick;
  endtask

  task automatic frame();
    next_frame = 1'b1;
    step();
  endtask

  task automatic frames_until(input int target);
    for (int i = 0; i < 64 && int'(level) != target; i++) frame();
    check("reach_level", 32'(level), target);
  endtask

  task automatic measure_duty(input int exp_high);
    int highs;
    highs = 0;
    tick_auto = 0;
    tick = 1'b1; step();
    tick = 1'b0; step();
    for (int i = 0; i < 256; i++) begin
      tick = 1'b1; step();
      if (backlight_pwm === 1'b1) highs++;
      tick = 1'b0; step();
    end
    check("pwm_duty", highs, exp_high);
    tick_auto = 1;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; next_frame = 1'b0; enable = 1'b0; brightness = 8'd0;
    repeat (3) step();
    check_en = 1;
    reset = 1'b0;
    tick_auto = 1;
    step();
    check("rst_state", 32'(state), 0);
    check("rst_display_on", 32'(display_on), 0);
    check("rst_pwm", 32'(backlight_pwm), 0);
    check("rst_pixels", 32'(pixels_enable), 0);
    check("rst_level", 32'(level), 0);

    // Power-up with fade to 64.
    brightness = 8'd64; enable = 1'b1;
    step();
    check("pu_display_on", 32'(display_on), 1);
    check("pu_state", 32'(state), 1);
    repeat (ON_DELAY - 1) frame();
    check("pu_hold_level", 32'(level), 0);
    check("pu_hold_state", 32'(state), 1);
    frame();
    check("ramp_entry_state", 32'(state), 2);
    check("ramp_entry_pixels", 32'(pixels_enable), 1);
    for (int i = 1; i <= 8; i++) begin
      frame();
      check("ramp_up_level", 32'(level), 8 * i);
    end
    check("on_state", 32'(state), 3);

    // Target tracking in ON.
    brightness = 8'd100;
    for (int i = 1; i <= 5; i++) begin
      frame();
      check("track_up_level", 32'(level), (i < 5) ? 64 + 8 * i : 100);
    end
    brightness = 8'd0;
    for (int i = 1; i <= 13; i++) begin
      frame();
      check("track_dn_level", 32'(level), (100 - 8 * i > 0) ? 100 - 8 * i : 0);
    end
    check("track_dn_state", 32'(state), 3);

    // Full power-down from level 64.
    brightness = 8'd64;
    frames_until(64);
    enable = 1'b0;
    step();
    check("rd_state", 32'(state), 4);
    check("rd_level_hold", 32'(level), 64);
    for (int i = 1; i <= 8; i++) begin
      frame();
      check("ramp_dn_level", 32'(level), 64 - 8 * i);
    end
    check("pd_state", 32'(state), 5);
    repeat (OFF_DELAY - 1) frame();
    check("pd_hold_state", 32'(state), 5);
    check("pd_display_on", 32'(display_on), 1);
    check("pd_pwm", 32'(backlight_pwm), 0);
    frame();
    check("off_state", 32'(state), 0);
    check("off_display_on", 32'(display_on), 0);

    // Reversal in the middle of a fade.
    enable = 1'b1; brightness = 8'd200;
    step();
    repeat (ON_DELAY) frame();
    repeat (3) frame();
    check("rev_level24", 32'(level), 24);
    enable = 1'b0;
    step();
    check("rev_rd_state", 32'(state), 4);
    frame();
    check("rev_dn_16", 32'(level), 16);
    frame();
    check("rev_dn_8", 32'(level), 8);
    enable = 1'b1;
    step();
    check("rev_ru_state", 32'(state), 2);
    frame();
    check("rev_up_16", 32'(level), 16);

    // PWM duty at the corner levels.
    brightness = 8'd1;
    frame();
    check("duty1_state", 32'(state), 3);
    check("duty1_level", 32'(level), 1);
    measure_duty(1);
    brightness = 8'd128; frames_until(128); measure_duty(128);
    brightness = 8'd255; frames_until(255); measure_duty(255);
    brightness = 8'd0;   frames_until(0);   measure_duty(0);

    // Reset while fully on.
    brightness = 8'd200; frames_until(200);
    reset = 1'b1;
    step();
    check("mid_rst_display_on", 32'(display_on), 0);
    check("mid_rst_pwm", 32'(backlight_pwm), 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_state", 32'(state), 0);
    reset = 1'b0;

    // Power-down runs to completion even if enable returns.
    step();
    check("pd2_pu_state", 32'(state), 1);
    enable = 1'b0;
    step();
    check("pd2_state", 32'(state), 5);
    enable = 1'b1;
    step();
    check("pd2_ignore_enable", 32'(state), 5);
    repeat (OFF_DELAY - 1) frame();
    check("pd2_hold", 32'(state), 5);
    frame();
    check("pd2_off", 32'(state), 0);
    step();
    check("pd2_repowerup", 32'(state), 1);

    // Randomized traffic against the model.
    tick_auto = 0;
    for (int i = 0; i < 20000; i++) begin
      reset      = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0)  brightness = 8'($urandom);
      next_frame = ($urandom_range(0, 7) == 0);
      tick       = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
